// File: rtl/frec_meter.sv
// frec_meter: receive-side frequency meter for a slow, asynchronous square wave.
// Brings clock_in into the system clock domain and emits one rise_tick per rising
// edge. It measures the rise-to-rise period in system clocks, declares lock once
// the period stays within TOL for LOCK_COUNT periods in a row, and pulses timeout
// when no edge arrives within TIMEOUT clocks.
module frec_meter #(
    parameter int CNT_W      = 16,
    parameter int TIMEOUT    = 1000,
    parameter int TOL        = 1,
    parameter int LOCK_COUNT = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clock_in,
    output logic             rise_tick,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);

    localparam int DIFF_W  = CNT_W + 1;
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] ELAPSED_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        ACQUIRE,
        LOCKED
    } state_t;

    // Synchroniser and edge-detect stage
    logic sync1_q;
    logic sync2_q;
    logic syncPrev_q;
    logic riseEdge_q;

    // Measurement state and registered outputs
    state_t             state_q,       state_d;
    logic [CNT_W-1:0]   elapsed_q,     elapsed_d;
    logic [CNT_W-1:0]   refPeriod_q,   refPeriod_d;
    logic [MATCH_W-1:0] matchCnt_q,    matchCnt_d;
    logic               riseTick_q,    riseTick_d;
    logic [CNT_W-1:0]   periodOut_q,   periodOut_d;
    logic               periodValid_q, periodValid_d;
    logic               locked_q,      locked_d;
    logic               timeout_q,     timeout_d;

    // Helpers for comparing a new period against the reference
    logic [DIFF_W-1:0]  periodDiff;
    logic               withinTol;
    logic [MATCH_W-1:0] matchInc;

    // Two-flop synchroniser, then a registered rising-edge detector; this gives the
    // fixed three-clock latency from the sampling edge to rise_tick.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            syncPrev_q <= 1'b0;
            riseEdge_q <= 1'b0;
        end else begin
            sync1_q    <= clock_in;
            sync2_q    <= sync1_q;
            syncPrev_q <= sync2_q;
            riseEdge_q <= sync2_q & ~syncPrev_q;
        end
    end

    // Unsigned distance between the current count and the reference period, one bit
    // wider than the counter so the subtraction cannot wrap.
    assign periodDiff = (elapsed_q >= refPeriod_q)
                      ? ({1'b0, elapsed_q} - {1'b0, refPeriod_q})
                      : ({1'b0, refPeriod_q} - {1'b0, elapsed_q});
    assign withinTol  = (periodDiff <= DIFF_W'(TOL));
    assign matchInc   = matchCnt_q + MATCH_W'(1);

    // State register for the FSM, the period counter and all registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            elapsed_q     <= '0;
            refPeriod_q   <= '0;
            matchCnt_q    <= '0;
            riseTick_q    <= 1'b0;
            periodOut_q   <= '0;
            periodValid_q <= 1'b0;
            locked_q      <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            elapsed_q     <= elapsed_d;
            refPeriod_q   <= refPeriod_d;
            matchCnt_q    <= matchCnt_d;
            riseTick_q    <= riseTick_d;
            periodOut_q   <= periodOut_d;
            periodValid_q <= periodValid_d;
            locked_q      <= locked_d;
            timeout_q     <= timeout_d;
        end
    end

    // Next-state and output logic. The counter restarts at 1 on the edge that
    // raises rise_tick, so at the next processed edge it holds the number of clocks
    // between the two rise_ticks. A rise always takes priority over the timeout.
    always_comb begin
        state_d       = state_q;
        elapsed_d     = elapsed_q;
        refPeriod_d   = refPeriod_q;
        matchCnt_d    = matchCnt_q;
        riseTick_d    = 1'b0;
        periodOut_d   = periodOut_q;
        periodValid_d = 1'b0;
        locked_d      = locked_q;
        timeout_d     = 1'b0;

        if (riseEdge_q) begin
            elapsed_d = CNT_W'(1);
        end else if (elapsed_q != ELAPSED_MAX) begin
            elapsed_d = elapsed_q + CNT_W'(1);
        end

        if (riseEdge_q) begin
            riseTick_d = 1'b1;
            case (state_q)
                IDLE: begin
                    state_d = ARM;
                end
                ARM: begin
                    periodOut_d   = elapsed_q;
                    periodValid_d = 1'b1;
                    refPeriod_d   = elapsed_q;
                    matchCnt_d    = '0;
                    state_d       = ACQUIRE;
                end
                ACQUIRE: begin
                    periodOut_d   = elapsed_q;
                    periodValid_d = 1'b1;
                    if (withinTol) begin
                        matchCnt_d = matchInc;
                        if (matchInc == MATCH_W'(LOCK_COUNT)) begin
                            locked_d = 1'b1;
                            state_d  = LOCKED;
                        end
                    end else begin
                        refPeriod_d = elapsed_q;
                        matchCnt_d  = '0;
                    end
                end
                LOCKED: begin
                    periodOut_d   = elapsed_q;
                    periodValid_d = 1'b1;
                    if (!withinTol) begin
                        locked_d    = 1'b0;
                        refPeriod_d = elapsed_q;
                        matchCnt_d  = '0;
                        state_d     = ACQUIRE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else if ((state_q != IDLE) && (elapsed_q > CNT_W'(TIMEOUT))) begin
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            state_d   = IDLE;
        end
    end

    assign rise_tick    = riseTick_q;
    assign period_out   = periodOut_q;
    assign period_valid = periodValid_q;
    assign locked       = locked_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_frec_meter.sv
// tb_frec_meter: directed bench for frec_meter. Each stimulus step pushes the
// hand-computed response it should produce; a monitor pops and compares whenever
// the DUT shows rise_tick, timeout or period_valid.
module tb_frec_meter;

    localparam int CNT_W = 16;

    logic             clock   = 1'b0;
    logic             reset_n = 1'b0;
    logic             clockIn = 1'b0;
    logic             riseTick;
    logic [CNT_W-1:0] periodOut;
    logic             periodValid;
    logic             locked;
    logic             timeoutPulse;

    typedef struct {
        bit isTimeout;
        bit valid;
        int period;
        bit locked;
        int gap;
    } exp_t;

    exp_t expQ[$];
    int   checks    = 0;
    int   errors    = 0;
    int   sinceRise = 0;

    frec_meter #(
        .CNT_W(CNT_W),
        .TIMEOUT(1000),
        .TOL(1),
        .LOCK_COUNT(4)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .clock_in(clockIn),
        .rise_tick(riseTick),
        .period_out(periodOut),
        .period_valid(periodValid),
        .locked(locked),
        .timeout(timeoutPulse)
    );

    // 10 ns system clock
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic expRise(input bit valid, input int period, input bit lck, input int gap);
        exp_t e;
        e.isTimeout = 1'b0;
        e.valid     = valid;
        e.period    = period;
        e.locked    = lck;
        e.gap       = gap;
        expQ.push_back(e);
    endtask

    task automatic expTimeout(input int period, input int gap);
        exp_t e;
        e.isTimeout = 1'b1;
        e.valid     = 1'b0;
        e.period    = period;
        e.locked    = 1'b0;
        e.gap       = gap;
        expQ.push_back(e);
    endtask

    // One rising edge followed by h high and l low clocks, driven on negedges
    task automatic applyStimulus(input int h, input int l);
        clockIn = 1'b1;
        repeat (h) @(negedge clock);
        clockIn = 1'b0;
        repeat (l) @(negedge clock);
    endtask

    // Same waveform, also checking that rise_tick appears exactly 3 clocks after
    // the posedge that first samples clock_in high
    task automatic applyFirstRise(input int h, input int l);
        clockIn = 1'b1;
        @(posedge clock);
        repeat (2) @(posedge clock);
        #1 checkOutput("latencyNotEarly", riseTick, 0);
        @(posedge clock);
        #1 checkOutput("latencyThree", riseTick, 1);
        @(negedge clock);
        repeat (h - 4) @(negedge clock);
        clockIn = 1'b0;
        repeat (l) @(negedge clock);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_riseTick"}, riseTick, 0);
        checkOutput({tag, "_periodOut"}, periodOut, 0);
        checkOutput({tag, "_periodValid"}, periodValid, 0);
        checkOutput({tag, "_locked"}, locked, 0);
        checkOutput({tag, "_timeout"}, timeoutPulse, 0);
    endtask

    // Monitor: compares every DUT output event against the next expectation
    always @(negedge clock) begin
        exp_t e;
        if (reset_n) begin
            sinceRise = sinceRise + 1;
            if (riseTick || timeoutPulse || periodValid) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedEvent: got rise=%0d timeout=%0d valid=%0d, expected no event",
                             riseTick, timeoutPulse, periodValid);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("riseTick", riseTick, !e.isTimeout);
                    checkOutput("timeout", timeoutPulse, e.isTimeout);
                    checkOutput("periodValid", periodValid, e.valid);
                    checkOutput("periodOut", periodOut, e.period);
                    checkOutput("locked", locked, e.locked);
                    if (e.gap != 0) checkOutput("eventGap", sinceRise, e.gap);
                end
                if (riseTick) sinceRise = 0;
            end
        end else begin
            sinceRise = 0;
        end
    end

    // Safety net so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenario
    initial begin
        reset_n = 1'b0;
        clockIn = 1'b0;
        repeat (3) begin
            @(negedge clock) clockIn = 1'b1;
            @(negedge clock) clockIn = 1'b0;
        end
        #1 checkAllZero("inReset");
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);

        // Acquire and lock on a 9/9 wave
        expRise(0, 0, 0, 0);
        applyFirstRise(9, 9);
        repeat (4) begin
            expRise(1, 18, 0, 18);
            applyStimulus(9, 9);
        end
        expRise(1, 18, 1, 18);  applyStimulus(9, 9);

        // Jitter within tolerance keeps lock: periods 18,19,17,18
        expRise(1, 18, 1, 18);  applyStimulus(10, 9);
        expRise(1, 19, 1, 19);  applyStimulus(9, 8);
        expRise(1, 17, 1, 17);  applyStimulus(9, 9);
        expRise(1, 18, 1, 18);  applyStimulus(11, 10);

        // Jump to 21 drops lock, four more 21s relock
        expRise(1, 21, 0, 21);  applyStimulus(11, 10);
        repeat (3) begin
            expRise(1, 21, 0, 21);
            applyStimulus(11, 10);
        end
        expRise(1, 21, 1, 21);
        expTimeout(21, 1001);
        applyStimulus(9, 1010);

        // After the timeout the next rise only re-arms
        expRise(0, 21, 0, 1019);  applyStimulus(500, 500);

        // A period of exactly 1000 is legal, then a stall times out
        expRise(1, 1000, 0, 1000);
        expTimeout(1000, 1001);
        applyStimulus(9, 1010);

        // A 1002-clock period: timeout at 1001, then the late rise only re-arms
        expRise(0, 1000, 0, 1019);
        expTimeout(1000, 1001);
        applyStimulus(500, 502);
        expRise(0, 1000, 0, 1002);  applyStimulus(9, 9);
        expRise(1, 18, 0, 18);      applyStimulus(9, 9);

        // Reset pulse while acquiring clears outputs without waiting for a clock
        expRise(1, 18, 0, 18);
        clockIn = 1'b1;
        repeat (9) @(negedge clock);
        clockIn = 1'b0;
        repeat (3) @(negedge clock);
        #2 reset_n = 1'b0;
        #1 checkAllZero("asyncReset");
        @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);

        // Full relock sequence from IDLE
        expRise(0, 0, 0, 0);  applyStimulus(9, 9);
        repeat (4) begin
            expRise(1, 18, 0, 18);
            applyStimulus(9, 9);
        end
        expRise(1, 18, 1, 18);  applyStimulus(9, 20);

        #1 checkOutput("queueEmpty", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
